dbus_arbiter: RTL and testbench
===============================

DBUS_ARBITER -- requirements
Module: dbus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: maximum BUSY cycles waiting on mem_ready before a transaction is aborted.
REQ-002 SHALL have parameter AW, default 32: width of the address and data buses.
REQ-003 SHALL have clk  in  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have rst  in  1: reset, asynchronous and active-high.
REQ-005 SHALL have req0/req1  in  1 each: access request from port 0 (CPU load/store stage) and port 1 (DMA/debug).
REQ-006 SHALL have we0/we1  in  1 each: 1 = store, 0 = load.
REQ-007 SHALL have addr0/addr1 and wdata0/wdata1  in  AW each: request address and store data.
REQ-008 SHALL have gnt0/gnt1  out  1 each: one-cycle pulse; the request has been accepted.
REQ-009 SHALL have done0/done1  out  1 each: one-cycle pulse; the transaction has completed.
REQ-010 SHALL have rdata  out  AW: load result, shared by both ports and valid in the done cycle.
REQ-011 SHALL have err  out  1: one-cycle pulse, coincident with done, when the transaction timed out.
REQ-012 SHALL have mem_en, mem_we  out  1 each, and mem_addr, mem_wdata  out  AW: memory-side command (drives daddrbus and databus).
REQ-013 SHALL have mem_rdata  in  AW and mem_ready  in  1: memory response.

Function
REQ-014 The FSM SHALL have exactly two states: IDLE and BUSY.
REQ-015 In IDLE, req is sampled at each edge; if any req is high, the winner's addr, we and wdata SHALL be latched, state becomes BUSY, and gnt of the winner is high for the following cycle only.
REQ-016 Arbitration SHALL be round-robin: a priority pointer selects the favoured port when both requests are high, and it flips to the other port at every completion, including timeouts.
REQ-017 When exactly one req is high, that port SHALL win regardless of the pointer.
REQ-018 In BUSY, mem_en SHALL be 1, mem_we/mem_addr/mem_wdata SHALL equal the latched values, and these SHALL be held stable until completion.
REQ-019 Outside BUSY, mem_en and mem_we SHALL be 0.
REQ-020 At an edge in BUSY with mem_ready=1: state becomes IDLE; the owner's done pulses high for the next cycle; for a load, rdata is loaded from mem_rdata; for a store, rdata is unchanged.
REQ-021 Minimum transaction latency SHALL be req-sample edge to done high = 2 cycles (mem_ready high in the first BUSY cycle).
REQ-022 A BUSY cycle counter SHALL be cleared on entry to BUSY.
REQ-023 If the counter reaches TIMEOUT without mem_ready, the FSM SHALL return to IDLE, pulse done of the owner together with err, and set rdata to 0.
REQ-024 If mem_ready arrives in the same edge as the timeout, the transaction SHALL complete normally with no err.
REQ-025 req SHALL be ignored in BUSY; a req still high in the done cycle is re-arbitrated at the next edge, giving 1 idle cycle between transactions.
REQ-026 A req dropped before gnt SHALL be treated as withdrawn, with no side effects.
REQ-027 gnt0 and gnt1 SHALL never be high together, and likewise done0 and done1.
REQ-028 The counter width SHALL be clog2(TIMEOUT+1) bits and SHALL saturate (no wrap-around).

Reset
REQ-029 On rst (asynchronous), the block SHALL set: state=IDLE; pointer favours port 0; the counter and latched request cleared.
REQ-030 On rst, all outputs (gnt*, done*, err, mem_*, rdata) SHALL be 0.
REQ-031 A rst during BUSY SHALL abandon the transaction: no done or err is issued, and mem_en falls immediately.
REQ-032 The first arbitration after reset release SHALL occur at the first rising edge with rst low.

Structure
REQ-033 A shared package SHALL hold the state enum (IDLE, BUSY), the default TIMEOUT, and the port-index constants.
REQ-034 Round-robin selection SHALL be a sub-module rr_pick2 (inputs: req0, req1, ptr; outputs: one-hot win).
REQ-035 The timeout counter SHALL be inline.

Verification
REQ-036 Load, single port: req0=1, we0=0, addr0=0x40, mem_ready=1 in the first BUSY cycle with mem_rdata=0xDEADBEEF -> gnt0 one cycle after sample; done0 two cycles after sample; rdata=0xDEADBEEF; err=0.
REQ-037 Simultaneous requests after reset: req0=req1=1 held -> port0 served first, then port1, then port0; gnt order 0,1,0; 1 idle cycle between transactions.
REQ-038 Store with wait states: req1=1, we1=1, addr1=0x100, wdata1=0x12345678, mem_ready delayed 4 cycles -> mem_en/mem_we/mem_addr/mem_wdata stable all 4 cycles; done1 after ready; rdata unchanged.
REQ-039 Timeout: TIMEOUT=15, mem_ready never asserted -> done0 and err pulse together 15 cycles after BUSY entry; rdata=0; pointer flips.
REQ-040 Reset mid-transaction: rst asserted 2 cycles into BUSY -> mem_en=0 immediately; no done; after release, a pending req0 is granted first.
REQ-041 Ready/timeout tie: mem_ready coincides with the TIMEOUT edge -> normal done, err=0, rdata=mem_rdata.

Source files
------------

// File: rtl/dbus_arbiter_pkg.sv
// rtl/dbus_arbiter_pkg.sv - shared types and constants for the data-bus arbiter
package dbus_arbiter_pkg;

   // Arbiter FSM states
   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

   // Default number of BUSY cycles allowed before a transaction is aborted
   localparam int TIMEOUT_DEFAULT = 15;

   // Default address/data width
   localparam int AW_DEFAULT = 32;

   // Port indices, also the bit positions in the one-hot win vector
   localparam int PORT0 = 0;
   localparam int PORT1 = 1;

endpackage

// File: rtl/dbus_arbiter_if.sv
// rtl/dbus_arbiter_if.sv - request ports and memory-side bus of the arbiter
interface dbus_arbiter_if #(
   parameter int AW = 32
);
   // Port 0 (CPU load/store) and port 1 (DMA/debug) requests
   logic          req0;
   logic          req1;
   logic          we0;
   logic          we1;
   logic [AW-1:0] addr0;
   logic [AW-1:0] addr1;
   logic [AW-1:0] wdata0;
   logic [AW-1:0] wdata1;

   // Responses to the requesting ports
   logic          gnt0;
   logic          gnt1;
   logic          done0;
   logic          done1;
   logic          err;
   logic [AW-1:0] rdata;

   // Memory-side command and response
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [AW-1:0] mem_wdata;
   logic [AW-1:0] mem_rdata;
   logic          mem_ready;

   // Arbiter view: takes requests and memory responses, drives everything else
   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
      input  mem_rdata, mem_ready,
      output gnt0, gnt1, done0, done1, err, rdata,
      output mem_en, mem_we, mem_addr, mem_wdata
   );

   // Requester/memory view: the environment around the arbiter
   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
      output mem_rdata, mem_ready,
      input  gnt0, gnt1, done0, done1, err, rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/dbus_arbiter_rr_pick2.sv
// rtl/dbus_arbiter_rr_pick2.sv - two-way round-robin pick, one-hot result
module rr_pick2
   import dbus_arbiter_pkg::*;
(
   input  logic       req0,
   input  logic       req1,
   input  logic       ptr,
   output logic [1:0] win
);

   // A lone request always wins; the pointer only breaks ties
   always_comb begin
      win = 2'b00;
      if (req0 && req1) begin
         win[PORT1] = ptr;
         win[PORT0] = ~ptr;
      end else begin
         win[PORT0] = req0;
         win[PORT1] = req1;
      end
   end

endmodule

// File: rtl/dbus_arbiter.sv
// rtl/dbus_arbiter.sv - two-port round-robin data-bus arbiter with ready timeout
module dbus_arbiter
   import dbus_arbiter_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT,
   parameter int AW      = AW_DEFAULT
) (
   input  logic          clk,
   input  logic          rst,
   dbus_arbiter_if.slave bus
);

   localparam int            CW     = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

   state_e        state_q, state_d;
   logic          ptr_q, ptr_d;        // 0 favours port 0, 1 favours port 1
   logic          owner_q, owner_d;    // port that owns the current transaction
   logic          we_q, we_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [AW-1:0] wdata_q, wdata_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] cnt_inc;

   logic          gnt0_q, gnt0_d;
   logic          gnt1_q, gnt1_d;
   logic          done0_q, done0_d;
   logic          done1_q, done1_d;
   logic          err_q, err_d;
   logic [AW-1:0] rdata_q, rdata_d;
   logic          mem_en_q, mem_en_d;
   logic          mem_we_q, mem_we_d;

   logic [1:0]    win;

   rr_pick2 u_pick (
      .req0 (bus.req0),
      .req1 (bus.req1),
      .ptr  (ptr_q),
      .win  (win)
   );

   // Saturating increment so the BUSY counter can never wrap
   always_comb begin
      cnt_inc = (cnt_q == TO_VAL) ? cnt_q : cnt_q + CW'(1);
   end

   // Next-state and next-output logic for the IDLE/BUSY controller
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      owner_d  = owner_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      cnt_d    = cnt_q;
      rdata_d  = rdata_q;
      gnt0_d   = 1'b0;
      gnt1_d   = 1'b0;
      done0_d  = 1'b0;
      done1_d  = 1'b0;
      err_d    = 1'b0;
      mem_en_d = 1'b0;
      mem_we_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (win != 2'b00) begin
               state_d  = BUSY;
               cnt_d    = '0;
               mem_en_d = 1'b1;
               if (win[PORT1]) begin
                  owner_d  = 1'b1;
                  we_d     = bus.we1;
                  addr_d   = bus.addr1;
                  wdata_d  = bus.wdata1;
                  mem_we_d = bus.we1;
                  gnt1_d   = 1'b1;
               end else begin
                  owner_d  = 1'b0;
                  we_d     = bus.we0;
                  addr_d   = bus.addr0;
                  wdata_d  = bus.wdata0;
                  mem_we_d = bus.we0;
                  gnt0_d   = 1'b1;
               end
            end
         end

         BUSY: begin
            // Ready wins over a timeout falling on the same edge
            if (bus.mem_ready) begin
               state_d = IDLE;
               ptr_d   = ~ptr_q;
               done0_d = ~owner_q;
               done1_d = owner_q;
               if (!we_q) begin
                  rdata_d = bus.mem_rdata;
               end
            end else if (cnt_inc == TO_VAL) begin
               state_d = IDLE;
               ptr_d   = ~ptr_q;
               done0_d = ~owner_q;
               done1_d = owner_q;
               err_d   = 1'b1;
               rdata_d = '0;
               cnt_d   = cnt_inc;
            end else begin
               cnt_d    = cnt_inc;
               mem_en_d = 1'b1;
               mem_we_d = we_q;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and registered outputs; reset abandons any transaction in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         ptr_q    <= 1'b0;
         owner_q  <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         cnt_q    <= '0;
         rdata_q  <= '0;
         gnt0_q   <= 1'b0;
         gnt1_q   <= 1'b0;
         done0_q  <= 1'b0;
         done1_q  <= 1'b0;
         err_q    <= 1'b0;
         mem_en_q <= 1'b0;
         mem_we_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         owner_q  <= owner_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         cnt_q    <= cnt_d;
         rdata_q  <= rdata_d;
         gnt0_q   <= gnt0_d;
         gnt1_q   <= gnt1_d;
         done0_q  <= done0_d;
         done1_q  <= done1_d;
         err_q    <= err_d;
         mem_en_q <= mem_en_d;
         mem_we_q <= mem_we_d;
      end
   end

   assign bus.gnt0      = gnt0_q;
   assign bus.gnt1      = gnt1_q;
   assign bus.done0     = done0_q;
   assign bus.done1     = done1_q;
   assign bus.err       = err_q;
   assign bus.rdata     = rdata_q;
   assign bus.mem_en    = mem_en_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_dbus_arbiter.sv
// tb/tb_dbus_arbiter.sv - directed vector bench for dbus_arbiter
module tb_dbus_arbiter;

   logic clk;
   logic rst;

   dbus_arbiter_if #(.AW(32)) bus ();

   dbus_arbiter #(
      .TIMEOUT (15),
      .AW      (32)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ctl bit order: {gnt0, gnt1, done0, done1, err, mem_en, mem_we}
   typedef struct {
      logic        rst;
      logic        req0;
      logic        req1;
      logic        we0;
      logic        we1;
      logic [31:0] addr0;
      logic [31:0] addr1;
      logic [31:0] wdata0;
      logic [31:0] wdata1;
      logic [31:0] mrdata;
      logic        mready;
      logic [6:0]  ctl;
      logic [31:0] rdata;
      logic        chk_mem;
      logic [31:0] maddr;
      logic [31:0] mwdata;
   } vec_t;

   vec_t vecs[$];
   int   n_total;
   int   n_pass;

   task automatic add(input logic r, input logic q0, input logic q1, input logic w0, input logic w1,
                      input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] d0,
                      input logic [31:0] d1, input logic [31:0] mrd, input logic mrdy,
                      input logic [6:0] ctl, input logic [31:0] rd, input logic cm,
                      input logic [31:0] ma, input logic [31:0] mw);
      vec_t v;
      v.rst = r; v.req0 = q0; v.req1 = q1; v.we0 = w0; v.we1 = w1;
      v.addr0 = a0; v.addr1 = a1; v.wdata0 = d0; v.wdata1 = d1;
      v.mrdata = mrd; v.mready = mrdy; v.ctl = ctl; v.rdata = rd;
      v.chk_mem = cm; v.maddr = ma; v.mwdata = mw;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [6:0] ctl_now();
      return {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.err, bus.mem_en, bus.mem_we};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_total = 0;
      n_pass  = 0;
      rst = 1'b1;
      bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
      bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
      bus.mem_rdata = '0; bus.mem_ready = 0;

      //  rst q0 q1 w0 w1 addr0  addr1  wdata0 wdata1        mrdata        rdy ctl         rdata         cm maddr  mwdata
      add(1, 0, 0, 0, 0, 32'h0,  32'h0,   32'h0, 32'h0,        32'h0,        0, 7'b0000000, 32'h0,        1, 32'h0,   32'h0);
      add(0, 1, 0, 0, 0, 32'h40, 32'h0,   32'h0, 32'h0,        32'h0,        0, 7'b1000010, 32'h0,        1, 32'h40,  32'h0);
      add(0, 0, 0, 0, 0, 32'h40, 32'h0,   32'h0, 32'h0,        32'hDEADBEEF, 1, 7'b0010000, 32'hDEADBEEF, 0, 32'h0,   32'h0);
      add(0, 0, 0, 0, 0, 32'h0,  32'h0,   32'h0, 32'h0,        32'h0,        0, 7'b0000000, 32'hDEADBEEF, 0, 32'h0,   32'h0);
      add(1, 0, 0, 0, 0, 32'h0,  32'h0,   32'h0, 32'h0,        32'h0,        0, 7'b0000000, 32'h0,        1, 32'h0,   32'h0);
      add(0, 1, 1, 0, 0, 32'h10, 32'h20,  32'h0, 32'h0,        32'hA,        1, 7'b1000010, 32'h0,        1, 32'h10,  32'h0);
      add(0, 1, 1, 0, 0, 32'h10, 32'h20,  32'h0, 32'h0,        32'hAAAA0000, 1, 7'b0010000, 32'hAAAA0000, 0, 32'h0,   32'h0);
      add(0, 1, 1, 0, 0, 32'h10, 32'h20,  32'h0, 32'h0,        32'hBBBB0000, 1, 7'b0100010, 32'hAAAA0000, 1, 32'h20,  32'h0);
      add(0, 1, 1, 0, 0, 32'h10, 32'h20,  32'h0, 32'h0,        32'hBBBB0000, 1, 7'b0001000, 32'hBBBB0000, 0, 32'h0,   32'h0);
      add(0, 1, 1, 0, 0, 32'h10, 32'h20,  32'h0, 32'h0,        32'hCCCC0000, 1, 7'b1000010, 32'hBBBB0000, 1, 32'h10,  32'h0);
      add(0, 0, 0, 0, 0, 32'h10, 32'h20,  32'h0, 32'h0,        32'hCCCC0000, 1, 7'b0010000, 32'hCCCC0000, 0, 32'h0,   32'h0);
      add(0, 0, 1, 0, 1, 32'h0,  32'h100, 32'h0, 32'h12345678, 32'h0,        0, 7'b0100011, 32'hCCCC0000, 1, 32'h100, 32'h12345678);
      for (int i = 0; i < 4; i++)
         add(0, 0, 0, 0, 1, 32'h0, 32'h999, 32'h0, 32'h0,      32'h0,        0, 7'b0000011, 32'hCCCC0000, 1, 32'h100, 32'h12345678);
      add(0, 0, 0, 0, 1, 32'h0,  32'h999, 32'h0, 32'h0,        32'hFFFFFFFF, 1, 7'b0001000, 32'hCCCC0000, 0, 32'h0,   32'h0);
      add(0, 0, 1, 0, 0, 32'h0,  32'h200, 32'h0, 32'h0,        32'h0,        0, 7'b0100010, 32'hCCCC0000, 1, 32'h200, 32'h0);
      add(0, 0, 0, 0, 0, 32'h0,  32'h200, 32'h0, 32'h0,        32'h00005555, 1, 7'b0001000, 32'h00005555, 0, 32'h0,   32'h0);

      #1;
      chk("reset ctl", 64'(ctl_now()), 64'(7'b0000000));
      chk("reset rdata", 64'(bus.rdata), 64'h0);

      foreach (vecs[i]) begin
         rst           = vecs[i].rst;
         bus.req0      = vecs[i].req0;
         bus.req1      = vecs[i].req1;
         bus.we0       = vecs[i].we0;
         bus.we1       = vecs[i].we1;
         bus.addr0     = vecs[i].addr0;
         bus.addr1     = vecs[i].addr1;
         bus.wdata0    = vecs[i].wdata0;
         bus.wdata1    = vecs[i].wdata1;
         bus.mem_rdata = vecs[i].mrdata;
         bus.mem_ready = vecs[i].mready;
         step();
         chk($sformatf("v%0d ctl", i), 64'(ctl_now()), 64'(vecs[i].ctl));
         chk($sformatf("v%0d rdata", i), 64'(bus.rdata), 64'(vecs[i].rdata));
         if (vecs[i].chk_mem) begin
            chk($sformatf("v%0d mem_addr", i), 64'(bus.mem_addr), 64'(vecs[i].maddr));
            chk($sformatf("v%0d mem_wdata", i), 64'(bus.mem_wdata), 64'(vecs[i].mwdata));
         end
      end

      // Timeout: port 0 load, memory never ready; pointer currently favours port 1
      bus.req0 = 1; bus.req1 = 0; bus.we0 = 0; bus.addr0 = 32'h44; bus.mem_ready = 0;
      step();
      chk("to gnt", 64'(ctl_now()), 64'(7'b1000010));
      bus.req0 = 0;
      for (int i = 0; i < 14; i++) begin
         step();
         chk($sformatf("to busy%0d", i + 2), 64'(ctl_now()), 64'(7'b0000010));
      end
      step();
      chk("to done_err", 64'(ctl_now()), 64'(7'b0010100));
      chk("to rdata", 64'(bus.rdata), 64'h0);

      // The timeout flipped the pointer back to port 0
      bus.req0 = 1; bus.req1 = 1; bus.we1 = 0; bus.addr0 = 32'h48; bus.addr1 = 32'h4C;
      step();
      chk("ptr flip gnt", 64'(ctl_now()), 64'(7'b1000010));
      chk("ptr flip addr", 64'(bus.mem_addr), 64'h48);
      bus.req0 = 0; bus.req1 = 0; bus.mem_ready = 1; bus.mem_rdata = 32'h77;
      step();
      chk("ptr flip done", 64'(ctl_now()), 64'(7'b0010000));
      chk("ptr flip rdata", 64'(bus.rdata), 64'h77);
      bus.mem_ready = 0;

      // Ready arrives on the same edge as the timeout
      bus.req0 = 1; bus.addr0 = 32'h80;
      step();
      chk("tie gnt", 64'(ctl_now()), 64'(7'b1000010));
      bus.req0 = 0;
      for (int i = 0; i < 14; i++) begin
         step();
         chk($sformatf("tie busy%0d", i + 2), 64'(ctl_now()), 64'(7'b0000010));
      end
      bus.mem_ready = 1; bus.mem_rdata = 32'h600DF00D;
      step();
      chk("tie done", 64'(ctl_now()), 64'(7'b0010000));
      chk("tie rdata", 64'(bus.rdata), 64'h600DF00D);
      bus.mem_ready = 0;

      // Reset two cycles into a port 1 transaction, port 0 pending
      bus.req1 = 1; bus.we1 = 0; bus.addr1 = 32'h300;
      step();
      chk("rst gnt1", 64'(ctl_now()), 64'(7'b0100010));
      bus.req0 = 1;
      step();
      chk("rst busy2", 64'(ctl_now()), 64'(7'b0000010));
      #3;
      rst = 1'b1;
      #1;
      chk("rst mem_en drop", 64'(ctl_now()), 64'(7'b0000000));
      step();
      chk("rst held", 64'(ctl_now()), 64'(7'b0000000));
      rst = 1'b0;
      step();
      chk("rst regrant", 64'(ctl_now()), 64'(7'b1000010));
      chk("rst regrant addr", 64'(bus.mem_addr), 64'h80);
      bus.req0 = 0; bus.req1 = 0; bus.mem_ready = 1; bus.mem_rdata = 32'h1234;
      step();
      chk("rst final done", 64'(ctl_now()), 64'(7'b0010000));
      chk("rst final rdata", 64'(bus.rdata), 64'h1234);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
